// File: rtl/xor_resp_chk.sv
// xor_resp_chk: response monitor for a 2-input XOR gate (y = a ^ b).
//
// A check run is launched by start_i. On each cycle that sample_vld_i is high
// during the run, the observed y_i is compared against the locally computed
// a_i ^ b_i. Vectors and mismatches are counted, and coverage of the four
// {a,b} combinations is tracked. The run finishes when every combination has
// been seen, or when TIMEOUT run cycles elapse without full coverage.
//
// Parameters:
//   CNT_W    width of the saturating vector/error counters
//   TIMEOUT  run cycles allowed before forced completion (0 = never)
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            asynchronous active-high reset
//   start_i          one-cycle pulse, starts a run from idle or done
//   sample_vld_i     a_i/b_i/y_i are to be checked this cycle
//   a_i, b_i         gate inputs as driven
//   y_i              gate output as observed
//   busy_o           run in progress
//   done_o           run finished, results held
//   pass_o           full coverage, zero errors, no timeout (valid with done_o)
//   timeout_o        run ended by timeout (valid with done_o)
//   vec_cnt_o        vectors checked this run
//   err_cnt_o        mismatches this run
//   cov_o            bit {a,b} set once that combination has been checked
//   first_err_vld_o  a mismatch has been captured this run
//   first_err_ab_o   {a,b} of the first mismatching vector
module xor_resp_chk #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sample_vld_i,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [3:0]       cov_o,
  output logic             first_err_vld_o,
  output logic [1:0]       first_err_ab_o
);

  // The timeout counter only needs to reach TIMEOUT-1.
  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = (TIMEOUT == 0) ? '0 : TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [3:0]        cov_q, cov_d;
  logic              first_err_vld_q, first_err_vld_d;
  logic [1:0]        first_err_ab_q, first_err_ab_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [1:0]        ab;
  logic              mismatch;

  assign ab = {a_i, b_i};
  // Case inequality so an X/Z on the observed output is flagged in simulation.
  assign mismatch = (y_i !== (a_i ^ b_i));

  always_comb begin
    state_d         = state_q;
    vec_cnt_d       = vec_cnt_q;
    err_cnt_d       = err_cnt_q;
    cov_d           = cov_q;
    first_err_vld_d = first_err_vld_q;
    first_err_ab_d  = first_err_ab_q;
    pass_d          = pass_q;
    timeout_d       = timeout_q;
    tmo_cnt_d       = tmo_cnt_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d         = StRun;
          vec_cnt_d       = '0;
          err_cnt_d       = '0;
          cov_d           = '0;
          first_err_vld_d = 1'b0;
          first_err_ab_d  = '0;
          pass_d          = 1'b0;
          timeout_d       = 1'b0;
          tmo_cnt_d       = '0;
        end
      end

      StRun: begin
        // Counts every run cycle and parks at its last value.
        if (TIMEOUT != 0 && tmo_cnt_q != TmoLast) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (sample_vld_i) begin
          if (vec_cnt_q != '1) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
          end
          if (mismatch) begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!first_err_vld_q) begin
              first_err_vld_d = 1'b1;
              first_err_ab_d  = ab;
            end
          end
          cov_d[ab] = 1'b1;
        end

        // Completing coverage wins over a timeout landing on the same edge.
        if (cov_d == 4'hF) begin
          state_d   = StDone;
          pass_d    = (err_cnt_d == '0);
          timeout_d = 1'b0;
        end else if (TIMEOUT != 0 && tmo_cnt_q == TmoLast) begin
          state_d   = StDone;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      vec_cnt_q       <= '0;
      err_cnt_q       <= '0;
      cov_q           <= '0;
      first_err_vld_q <= 1'b0;
      first_err_ab_q  <= '0;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
      tmo_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      vec_cnt_q       <= vec_cnt_d;
      err_cnt_q       <= err_cnt_d;
      cov_q           <= cov_d;
      first_err_vld_q <= first_err_vld_d;
      first_err_ab_q  <= first_err_ab_d;
      pass_q          <= pass_d;
      timeout_q       <= timeout_d;
      tmo_cnt_q       <= tmo_cnt_d;
    end
  end

  assign busy_o          = (state_q == StRun);
  assign done_o          = (state_q == StDone);
  assign pass_o          = pass_q;
  assign timeout_o       = timeout_q;
  assign vec_cnt_o       = vec_cnt_q;
  assign err_cnt_o       = err_cnt_q;
  assign cov_o           = cov_q;
  assign first_err_vld_o = first_err_vld_q;
  assign first_err_ab_o  = first_err_ab_q;

endmodule

// File: tb/tb_xor_resp_chk.sv
// Bench for xor_resp_chk. Two instances share all stimulus: instance A uses the
// default parameters, instance B uses narrow counters and a short timeout so
// saturation and timeout behaviour are exercised by the same sequences.
module tb_xor_resp_chk;

  logic clk = 1'b0;
  logic rst;
  logic start, vld, a, b, y;

  always #5 clk = ~clk;

  logic       busy_a, done_a, pass_a, tmo_a, fev_a;
  logic [7:0] vec_a, err_a;
  logic [3:0] cov_a;
  logic [1:0] feab_a;

  logic       busy_b, done_b, pass_b, tmo_b, fev_b;
  logic [2:0] vec_b, err_b;
  logic [3:0] cov_b;
  logic [1:0] feab_b;

  xor_resp_chk #(.CNT_W(8), .TIMEOUT(1000)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sample_vld_i(vld),
    .a_i(a), .b_i(b), .y_i(y),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .timeout_o(tmo_a),
    .vec_cnt_o(vec_a), .err_cnt_o(err_a), .cov_o(cov_a),
    .first_err_vld_o(fev_a), .first_err_ab_o(feab_a)
  );

  xor_resp_chk #(.CNT_W(3), .TIMEOUT(10)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sample_vld_i(vld),
    .a_i(a), .b_i(b), .y_i(y),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .timeout_o(tmo_b),
    .vec_cnt_o(vec_b), .err_cnt_o(err_b), .cov_o(cov_b),
    .first_err_vld_o(fev_b), .first_err_ab_o(feab_b)
  );

  // Reference model, one entry per instance. Phase: 0 idle, 1 running, 2 done.
  int lim[2]  = '{1000, 10};
  int cmax[2] = '{255, 7};
  int m_phase[2], m_vec[2], m_err[2], m_cov[2], m_fev[2], m_feab[2];
  int m_pass[2], m_to[2], m_runcyc[2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_vec[i] = 0; m_err[i] = 0; m_cov[i] = 0;
      m_fev[i] = 0; m_feab[i] = 0; m_pass[i] = 0; m_to[i] = 0; m_runcyc[i] = 0;
    end
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input logic st, input logic v, input logic ia, input logic ib,
                            input logic iy);
    int idx;
    idx = int'({ia, ib});
    for (int i = 0; i < 2; i++) begin
      if (m_phase[i] == 1) begin
        m_runcyc[i]++;
        if (v) begin
          m_vec[i] = (m_vec[i] < cmax[i]) ? m_vec[i] + 1 : cmax[i];
          if (iy !== (ia ^ ib)) begin
            m_err[i] = (m_err[i] < cmax[i]) ? m_err[i] + 1 : cmax[i];
            if (m_fev[i] == 0) begin
              m_fev[i]  = 1;
              m_feab[i] = idx;
            end
          end
          m_cov[i] = m_cov[i] | (1 << idx);
        end
        if (m_cov[i] == 15) begin
          m_phase[i] = 2;
          m_pass[i]  = (m_err[i] == 0) ? 1 : 0;
          m_to[i]    = 0;
        end else if (lim[i] != 0 && m_runcyc[i] == lim[i]) begin
          m_phase[i] = 2;
          m_pass[i]  = 0;
          m_to[i]    = 1;
        end
      end else if (st) begin
        m_phase[i] = 1; m_vec[i] = 0; m_err[i] = 0; m_cov[i] = 0; m_fev[i] = 0;
        m_feab[i] = 0; m_pass[i] = 0; m_to[i] = 0; m_runcyc[i] = 0;
      end
    end
  endtask

  task automatic cmp_dut(input int i, input string p, input logic busy_g, input logic done_g,
                         input logic pass_g, input logic to_g, input logic [31:0] vec_g,
                         input logic [31:0] err_g, input logic [3:0] cov_g,
                         input logic fev_g, input logic [1:0] feab_g);
    check({p, ".busy"},    32'(busy_g), 32'(m_phase[i] == 1));
    check({p, ".done"},    32'(done_g), 32'(m_phase[i] == 2));
    check({p, ".pass"},    32'(pass_g), 32'(m_pass[i]));
    check({p, ".timeout"}, 32'(to_g),   32'(m_to[i]));
    check({p, ".vec_cnt"}, vec_g,       32'(m_vec[i]));
    check({p, ".err_cnt"}, err_g,       32'(m_err[i]));
    check({p, ".cov"},     32'(cov_g),  32'(m_cov[i]));
    check({p, ".fe_vld"},  32'(fev_g),  32'(m_fev[i]));
    check({p, ".fe_ab"},   32'(feab_g), 32'(m_feab[i]));
  endtask

  task automatic compare_all();
    cmp_dut(0, "A", busy_a, done_a, pass_a, tmo_a, 32'(vec_a), 32'(err_a), cov_a, fev_a, feab_a);
    cmp_dut(1, "B", busy_b, done_b, pass_b, tmo_b, 32'(vec_b), 32'(err_b), cov_b, fev_b, feab_b);
  endtask

  // Apply inputs for one cycle, advance the model, sample after the edge.
  task automatic cyc(input logic st, input logic v, input logic ia, input logic ib,
                     input logic iy);
    start = st; vld = v; a = ia; b = ib; y = iy;
    model_step(st, v, ia, ib, iy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic go();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vec(input logic ia, input logic ib, input logic iy);
    cyc(1'b0, 1'b1, ia, ib, iy);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic ra, rb;
    rst = 1'b1; start = 1'b0; vld = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Sample while idle is ignored.
    vec(1'b0, 1'b0, 1'b0);

    // Clean run.
    go(); vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);
    idle();

    // Bad third vector.
    go(); vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 0); vec(1, 1, 0);

    // Repeated vectors before completion; samples in DONE ignored.
    go(); vec(0, 0, 0); vec(0, 0, 0); vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);
    vec(0, 0, 1);

    // Unknown on y counts as a mismatch.
    go(); vec(0, 0, 1'bx); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);

    // Partial coverage: B times out, A finishes later.
    go(); vec(0, 0, 0); vec(1, 1, 0);
    repeat (10) idle();
    vec(0, 1, 1); vec(1, 0, 1);

    // Saturating counters on B, then timeout.
    go();
    repeat (9) vec(0, 0, 1);
    vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);

    // Asynchronous reset mid-run.
    go(); vec(0, 0, 0); vec(0, 1, 1);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    #2 rst = 1'b0;
    vec(1, 0, 1); vec(1, 1, 0); vec(0, 0, 0);

    // Restart from DONE, with a start pulse in the middle of the run.
    go(); vec(0, 0, 0); vec(0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);
    go(); vec(0, 0, 0); cyc(1, 1, 0, 1, 1); vec(1, 0, 1); vec(1, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      ra = 1'($urandom_range(1));
      rb = 1'($urandom_range(1));
      cyc(1'($urandom_range(15) == 0), 1'($urandom_range(3) != 0), ra, rb,
          (ra ^ rb) ^ 1'($urandom_range(9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_resp_chk.md
Name: xor_resp_chk

Overview:
- Self-checking response monitor for the behavioural 2-input XOR gate (Y = A ^ B); the receiving end of the stimulus sequence that drives A/B.
- Samples A, B and Y on a valid strobe and compares Y against the locally computed A^B.
- Counts vectors and mismatches, tracks coverage of all four input combinations, and reports done/pass.
- Sits beside the XOR instance in simulation and in on-chip BIST wrappers.

Parameters:
- CNT_W, 8, width of vector and error counters (saturating)
- TIMEOUT, 1000, clock cycles allowed in RUN before forced completion; 0 disables the timeout

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a check run (accepted in IDLE or DONE)
- sample_vld  in  1  A/B/Y are stable and must be checked this cycle
- a  in  1  gate input A as driven
- b  in  1  gate input B as driven
- y  in  1  gate output Y as observed
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done: run completed with full coverage, zero errors, no timeout
- timeout  out  1  valid when done: run ended by TIMEOUT
- vec_cnt  out  CNT_W  vectors checked this run
- err_cnt  out  CNT_W  mismatches this run
- cov  out  4  bit index {a,b} set once that combination is checked
- first_err_vld  out  1  a mismatch has been captured this run
- first_err_ab  out  2  {a,b} of the first mismatching vector

Behaviour:
- Reset (async, any time, including mid-run):
  - state = IDLE.
  - All outputs 0: busy, done, pass, timeout, vec_cnt, err_cnt, cov, first_err_vld, first_err_ab.
  - Timeout counter = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start -> RUN. On entry to RUN, clear counters, cov, first_err_*, timeout counter, pass and timeout.
  - RUN: start is ignored.
  - RUN -> DONE when the cov value after this cycle's update is 4'b1111. Transition happens on the same edge that records the last combination.
  - RUN -> DONE with timeout=1 when the timeout counter reaches TIMEOUT-1 and coverage is still incomplete. Coverage completion on that same cycle takes priority, giving timeout=0.
  - DONE: holds all results. start -> RUN, clearing state exactly as on entry from IDLE. sample_vld is ignored.
  - sample_vld in IDLE is ignored; no counter changes.
- Check rule, RUN only, per edge with sample_vld=1:
  - exp = a ^ b; mismatch = (y != exp).
  - vec_cnt += 1, saturating at 2^CNT_W-1.
  - If mismatch: err_cnt += 1 (saturating).
  - If mismatch and first_err_vld=0: set first_err_vld and capture first_err_ab = {a,b}.
  - cov[{a,b}] <= 1.
  - X/Z on y counts as a mismatch in simulation (use !== semantics).
- Latency:
  - All outputs are registered and update on the edge that samples sample_vld.
  - done/pass are visible in the cycle after the completing sample.
  - pass = (err_cnt_next == 0) && !timeout, computed on the DONE-entry edge.
- Timeout counter:
  - Increments every RUN cycle, whether or not sample_vld is high.
  - Does not wrap.
  - Unused when TIMEOUT = 0.
- Repeated vectors: combinations already covered still count in vec_cnt and err_cnt; cov is unchanged.

Test Plan:
- Reset, start, then four vectors (a,b,y) = (0,0,0), (0,1,1), (1,0,1), (1,1,0) on consecutive cycles -> after the 4th edge: done=1, pass=1, vec_cnt=4, err_cnt=0, cov=4'b1111, first_err_vld=0.
- Same run with the third vector y=0 -> done=1, pass=0, err_cnt=1, first_err_vld=1, first_err_ab=2'b10.
- Vectors (0,0,0) x3, then (0,1,1), (1,0,1), (1,1,0) -> vec_cnt=6, done asserted only after (1,1,0), pass=1.
- TIMEOUT=10, start, only (0,0,0) and (1,1,0) applied -> after 10 RUN cycles: done=1, timeout=1, pass=0, cov=4'b1001.
- Assert rst mid-run after 2 vectors -> immediately (asynchronously) all outputs 0 and state IDLE. sample_vld without a new start -> vec_cnt stays 0.
- In DONE, pulse start, then the four correct vectors -> counters restart from 0 and end at vec_cnt=4, pass=1. Start pulsed during RUN -> no effect on counts.
